ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller placed directly in front of the team's dual-port RAM; turns that RAM into a first-in-first-out buffer.
- Port A of the RAM is the write port and port B is the read port; the RAM's data storage is used unchanged.
- Generates pointers, full/empty, occupancy and thresholds, plus error flags for the client.
- Aligns read data with the RAM's 1-cycle registered read latency and flags it with rd_valid.

---
 rtl/ram_fifo_ctrl.sv | 121 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that sits in front of a dual-port RAM.
// Port A writes and port B reads. Read data follows the RAM's 1-cycle registered latency.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int AF_LEVEL   = 56,
    parameter int AE_LEVEL   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_rdata_b
);

    localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                almost_full_q, almost_full_d;
    logic                almost_empty_q, almost_empty_d;
    logic                rd_valid_q, rd_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the registered (pre-edge) flags, so port A and port B never touch a live entry together.
    always_comb begin
        wr_acc = wr_en & ~full_q;
        rd_acc = rd_en & ~empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase

        // Equal low bits with different wrap bits mean the write pointer has lapped the read pointer.
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
        almost_full_d  = (count_d >= AF_CNT);
        almost_empty_d = (count_d <= AE_CNT);

        rd_valid_d  = rd_acc;
        overflow_d  = overflow_q  | (wr_en & full_q);
        underflow_d = underflow_q | (rd_en & empty_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            rd_valid_q     <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            rd_valid_q     <= rd_valid_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // The write strobe is gated by rst so the RAM cannot be written while the controller is held in reset.
    assign ram_we_a   = wr_acc & rst;
    assign ram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_data_a = wr_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr_q[ADDR_WIDTH-1:0];

    assign rd_data      = ram_rdata_b;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural dual-port RAM (registered port-B read).
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full, empty, almost_full, almost_empty;
    logic [6:0] count;
    logic       overflow, underflow;
    logic       ram_we_a;
    logic [5:0] ram_addr_a;
    logic [7:0] ram_data_a;
    logic       ram_we_b;
    logic [5:0] ram_addr_b;
    logic [7:0] ram_rdata_b;

    logic [7:0] mem [0:63];

    int errors = 0;
    int checks = 0;

    ram_fifo_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(6),
        .AF_LEVEL  (56),
        .AE_LEVEL  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .ram_we_a    (ram_we_a),
        .ram_addr_a  (ram_addr_a),
        .ram_data_a  (ram_data_a),
        .ram_we_b    (ram_we_b),
        .ram_addr_b  (ram_addr_b),
        .ram_rdata_b (ram_rdata_b)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write on A, registered read on B every cycle.
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_rdata_b <= mem[ram_addr_b];
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b1; wr_data = 8'h99; rd_en = 1'b0;
        repeat (2) cycle();
        checks++;
        if ({empty, almost_empty, full, almost_full, rd_valid} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 11000", {empty, almost_empty, full, almost_full, rd_valid});
        end
        checks++;
        if (count !== 7'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if ({ram_we_a, ram_we_b, overflow, underflow} !== 4'b0000) begin
            errors++; $display("FAIL reset_we_err: got %b expected 0000", {ram_we_a, ram_we_b, overflow, underflow});
        end
        wr_en = 1'b0;
        rst = 1'b1;
        cycle();
        checks++;
        if ({empty, count} !== {1'b1, 7'd0}) begin
            errors++; $display("FAIL idle_after_reset: got empty=%b count=%0d expected empty=1 count=0", empty, count);
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = vals[i];
            cycle();
        end
        wr_en = 1'b0;
        checks++;
        if ({count, empty, rd_valid} !== {7'd3, 1'b0, 1'b0}) begin
            errors++; $display("FAIL push3: got count=%0d empty=%b rd_valid=%b expected 3 0 0", count, empty, rd_valid);
        end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            cycle();
            checks++;
            if ({rd_valid, rd_data} !== {1'b1, vals[i]}) begin
                errors++; $display("FAIL pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, rd_valid, rd_data, vals[i]);
            end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++; $display("FAIL empty_after_pop3: got %b expected 1", empty);
        end
        cycle();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            cycle();
            checks++;
            if (count !== 7'(i + 1)) begin
                errors++; $display("FAIL fill_count: got %0d expected %0d", count, i + 1);
            end
            if (i + 1 == 8 || i + 1 == 9) begin
                checks++;
                if (almost_empty !== (i + 1 == 8)) begin
                    errors++; $display("FAIL almost_empty@%0d: got %b expected %b", i + 1, almost_empty, (i + 1 == 8));
                end
            end
            if (i + 1 == 55 || i + 1 == 56) begin
                checks++;
                if (almost_full !== (i + 1 == 56)) begin
                    errors++; $display("FAIL almost_full@%0d: got %b expected %b", i + 1, almost_full, (i + 1 == 56));
                end
            end
        end
        checks++;
        if ({full, overflow} !== 2'b10) begin
            errors++; $display("FAIL full64: got full=%b overflow=%b expected 1 0", full, overflow);
        end
        wr_data = 8'hEE;
        #1;
        checks++;
        if (ram_we_a !== 1'b0) begin
            errors++; $display("FAIL we_when_full: got %b expected 0", ram_we_a);
        end
        cycle();
        wr_en = 1'b0;
        checks++;
        if ({overflow, full, count} !== {1'b1, 1'b1, 7'd64}) begin
            errors++; $display("FAIL overflow: got ovf=%b full=%b count=%0d expected 1 1 64", overflow, full, count);
        end
    endtask

    task automatic test_full_push_pop();
        wr_en = 1'b1; wr_data = 8'hAA; rd_en = 1'b1;
        #1;
        checks++;
        if (ram_we_a !== 1'b0) begin
            errors++; $display("FAIL full_pushpop_we: got %b expected 0", ram_we_a);
        end
        cycle();
        wr_en = 1'b0;
        checks++;
        if ({rd_valid, rd_data, count, full} !== {1'b1, 8'h00, 7'd63, 1'b0}) begin
            errors++; $display("FAIL full_pushpop: got valid=%b data=%h count=%0d full=%b expected 1 00 63 0",
                               rd_valid, rd_data, count, full);
        end
        for (int i = 1; i < 64; i++) begin
            cycle();
            checks++;
            if ({rd_valid, rd_data} !== {1'b1, 8'(i)}) begin
                errors++; $display("FAIL drain%0d: got valid=%b data=%h expected valid=1 data=%h", i, rd_valid, rd_data, 8'(i));
            end
        end
        rd_en = 1'b0;
        cycle();
        checks++;
        if ({rd_valid, empty, almost_empty, underflow, count} !== {4'b0110, 7'd0}) begin
            errors++; $display("FAIL drained: got valid=%b empty=%b ae=%b udf=%b count=%0d expected 0 1 1 0 0",
                               rd_valid, empty, almost_empty, underflow, count);
        end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        checks++;
        if ({underflow, rd_valid, count} !== {2'b10, 7'd0}) begin
            errors++; $display("FAIL underflow: got udf=%b valid=%b count=%0d expected 1 0 0", underflow, rd_valid, count);
        end
        wr_en = 1'b1; wr_data = 8'h5C; rd_en = 1'b1;
        cycle();
        wr_en = 1'b0;
        checks++;
        if ({count, rd_valid, empty} !== {7'd1, 2'b00}) begin
            errors++; $display("FAIL empty_pushpop: got count=%0d valid=%b empty=%b expected 1 0 0", count, rd_valid, empty);
        end
        cycle();
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, rd_data, empty} !== {1'b1, 8'h5C, 1'b1}) begin
            errors++; $display("FAIL pop_5c: got valid=%b data=%h empty=%b expected 1 5c 1", rd_valid, rd_data, empty);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        wr_en = 1'b1; wr_data = 8'd3;
        cycle();
        for (int k = 1; k <= 200; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(k * 7 + 3);
            cycle();
            checks++;
            if ({rd_valid, rd_data, count} !== {1'b1, 8'((k - 1) * 7 + 3), 7'd1}) begin
                errors++;
                if (bad < 5)
                    $display("FAIL stream%0d: got valid=%b data=%h count=%0d expected 1 %h 1",
                             k, rd_valid, rd_data, count, 8'((k - 1) * 7 + 3));
                bad++;
            end
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({count, empty, rd_valid, full, overflow, underflow} !== {7'd0, 5'b10000}) begin
            errors++; $display("FAIL async_reset: got count=%0d empty=%b valid=%b full=%b ovf=%b udf=%b expected 0 1 0 0 0 0",
                               count, empty, rd_valid, full, overflow, underflow);
        end
        checks++;
        if (ram_we_a !== 1'b0) begin
            errors++; $display("FAIL we_in_reset: got %b expected 0", ram_we_a);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if ({count, empty, almost_empty, rd_valid} !== {7'd0, 3'b110}) begin
            errors++; $display("FAIL post_reset: got count=%0d empty=%b ae=%b valid=%b expected 0 1 1 0",
                               count, empty, almost_empty, rd_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_full_push_pop();
        test_underflow();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
